// File: rtl/spi_rx_frame_fifo_if.sv
// Handshake bundle for the SPI receive frame FIFO: word input side, frame output side and status.
// The master modport is the producer/consumer side and the slave modport is the FIFO.
interface spi_rx_frame_fifo_if #(
  parameter int DSIZE       = 8,
  parameter int FRAME_BYTES = 15,
  parameter int DEPTH       = 4
);
  localparam int FW = FRAME_BYTES * DSIZE;
  localparam int LW = $clog2(FRAME_BYTES + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_valid;
  logic [DSIZE-1:0] wr_data;
  logic             wr_ready;
  logic             frame_flush;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    out_data;
  logic [LW-1:0]    out_len;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             ovf_clr;

  modport master (
    output wr_valid, wr_data, frame_flush, out_ready, ovf_clr,
    input  wr_ready, out_valid, out_data, out_len, count, overflow
  );

  modport slave (
    input  wr_valid, wr_data, frame_flush, out_ready, ovf_clr,
    output wr_ready, out_valid, out_data, out_len, count, overflow
  );
endinterface

// File: rtl/spi_rx_frame_fifo.sv
// Packs received SPI words into frames and queues up to DEPTH frames with first-word fall-through.
// Words that arrive while the queue is full are dropped and flagged on the sticky overflow bit.
module spi_rx_frame_fifo #(
  parameter int DSIZE       = 8,
  parameter int FRAME_BYTES = 15,
  parameter int DEPTH       = 4,
  parameter bit MSB_FIRST   = 1'b0
) (
  input logic                clk,
  input logic                rst,
  spi_rx_frame_fifo_if.slave bus
);
  localparam int FW = FRAME_BYTES * DSIZE;
  localparam int LW = $clog2(FRAME_BYTES + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FRAME_LEN = LW'(FRAME_BYTES);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [LW-1:0] byte_cnt_q, byte_cnt_d;
  logic [FW-1:0] shadow_q, shadow_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ready_q, wr_ready_d;
  logic          overflow_q, overflow_d;

  logic [FW-1:0] mem_data [DEPTH];
  logic [LW-1:0] mem_len  [DEPTH];

  logic          accept, drop, full_commit, flush_commit, flush_drop, commit, pop;
  logic [LW-1:0] lane, eff_len;
  logic [FW-1:0] shadow_wr;

  assign accept       = bus.wr_valid && wr_ready_q;
  assign drop         = bus.wr_valid && !wr_ready_q;
  assign lane         = MSB_FIRST ? (FRAME_LEN - LW'(1) - byte_cnt_q) : byte_cnt_q;
  // Effective length counts the word accepted this cycle so a flush can include it.
  assign eff_len      = byte_cnt_q + {{(LW-1){1'b0}}, accept};
  assign full_commit  = accept && (eff_len == FRAME_LEN);
  assign flush_commit = bus.frame_flush && wr_ready_q && (eff_len != '0) && !full_commit;
  assign flush_drop   = bus.frame_flush && !wr_ready_q && (byte_cnt_q != '0);
  assign commit       = full_commit || flush_commit;
  assign pop          = (count_q != '0) && bus.out_ready;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    shadow_wr = shadow_q;
    if (accept) shadow_wr[int'(lane) * DSIZE +: DSIZE] = bus.wr_data;
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_wr;
    if (commit || flush_drop) begin
      byte_cnt_d = '0;
      shadow_d   = '0;
    end else if (accept) begin
      byte_cnt_d = eff_len;
    end

    wr_ptr_d = commit ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (commit && !pop)      count_d = count_q + CW'(1);
    else if (!commit && pop) count_d = count_q - CW'(1);
    wr_ready_d = (count_d < DEPTH_CNT);

    overflow_d = overflow_q;
    if (drop || flush_drop) overflow_d = 1'b1;
    else if (bus.ovf_clr)   overflow_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      shadow_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: frame storage is deliberately not reset; count gates every read so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_data[wr_ptr_q] <= shadow_wr;
      mem_len[wr_ptr_q]  <= eff_len;
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = (count_q != '0) ? mem_data[rd_ptr_q] : '0;
  assign bus.out_len   = (count_q != '0) ? mem_len[rd_ptr_q]  : '0;
  assign bus.count     = count_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_spi_rx_frame_fifo.sv
// Directed bench for spi_rx_frame_fifo: an LSB-first and an MSB-first instance see identical stimulus
// and are checked against hand-computed frames, a vector table and a few multi-cycle sequences.
module tb_spi_rx_frame_fifo;
  localparam int DSIZE       = 8;
  localparam int FRAME_BYTES = 15;
  localparam int DEPTH       = 4;
  localparam int FW          = FRAME_BYTES * DSIZE;

  localparam logic [FW-1:0] F1_LSB  = 120'h0F0E0D0C0B0A090807060504030201;
  localparam logic [FW-1:0] F1_MSB  = 120'h0102030405060708090A0B0C0D0E0F;
  localparam logic [FW-1:0] ABC_LSB = 120'h000000000000000000000000CCBBAA;
  localparam logic [FW-1:0] ABC_MSB = 120'hAABBCC000000000000000000000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_rx_frame_fifo_if #(.DSIZE(DSIZE), .FRAME_BYTES(FRAME_BYTES), .DEPTH(DEPTH)) bus_lsb ();
  spi_rx_frame_fifo_if #(.DSIZE(DSIZE), .FRAME_BYTES(FRAME_BYTES), .DEPTH(DEPTH)) bus_msb ();

  assign bus_msb.wr_valid    = bus_lsb.wr_valid;
  assign bus_msb.wr_data     = bus_lsb.wr_data;
  assign bus_msb.frame_flush = bus_lsb.frame_flush;
  assign bus_msb.out_ready   = bus_lsb.out_ready;
  assign bus_msb.ovf_clr     = bus_lsb.ovf_clr;

  spi_rx_frame_fifo #(.DSIZE(DSIZE), .FRAME_BYTES(FRAME_BYTES), .DEPTH(DEPTH), .MSB_FIRST(1'b0))
    u_dut_lsb (.clk(clk), .rst(rst), .bus(bus_lsb));
  spi_rx_frame_fifo #(.DSIZE(DSIZE), .FRAME_BYTES(FRAME_BYTES), .DEPTH(DEPTH), .MSB_FIRST(1'b1))
    u_dut_msb (.clk(clk), .rst(rst), .bus(bus_msb));

  typedef struct {
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          flush;
    logic          out_ready;
    logic          exp_valid;
    logic [3:0]    exp_len;
    logic [2:0]    exp_count;
    logic [FW-1:0] exp_lsb;
    logic [FW-1:0] exp_msb;
  } vec_t;

  vec_t vecs [16];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] d, input logic fl, input logic rdy,
                        input logic clr);
    bus_lsb.wr_valid    = v;
    bus_lsb.wr_data     = d;
    bus_lsb.frame_flush = fl;
    bus_lsb.out_ready   = rdy;
    bus_lsb.ovf_clr     = clr;
  endtask

  // Words first, first+1, ... placed in lanes by the selected order; unused lanes stay zero.
  function automatic logic [FW-1:0] make_frame(input logic [7:0] first, input int len, input bit msb);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < len; i++) begin
      int ln;
      ln = msb ? (FRAME_BYTES - 1 - i) : i;
      f[ln*8 +: 8] = first + 8'(i);
    end
    return f;
  endfunction

  task automatic write_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, first + 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_head(input string name, input logic [7:0] first, input int len);
    check({name, "_valid"}, bus_lsb.out_valid, 1'b1);
    check({name, "_len"}, bus_lsb.out_len, len);
    check({name, "_lsb"}, bus_lsb.out_data, make_frame(first, len, 1'b0));
    check({name, "_msb"}, bus_msb.out_data, make_frame(first, len, 1'b1));
  endtask

  task automatic check_empty(input string name);
    check({name, "_valid"}, bus_lsb.out_valid, 1'b0);
    check({name, "_data"}, bus_lsb.out_data, '0);
    check({name, "_len"}, bus_lsb.out_len, 0);
    check({name, "_count"}, bus_lsb.count, 0);
  endtask

  initial begin
    int         sent, popped, cyc;
    logic       v, r;
    logic [7:0] d;

    // Table: 15 words 0x01..0x0F into an empty FIFO, then one pop.
    for (int i = 0; i < 15; i++) begin
      vecs[i].wr_valid  = 1'b1;
      vecs[i].wr_data   = 8'(i + 1);
      vecs[i].flush     = 1'b0;
      vecs[i].out_ready = 1'b0;
      vecs[i].exp_valid = (i == 14);
      vecs[i].exp_len   = (i == 14) ? 4'd15 : 4'd0;
      vecs[i].exp_count = (i == 14) ? 3'd1 : 3'd0;
      vecs[i].exp_lsb   = (i == 14) ? F1_LSB : '0;
      vecs[i].exp_msb   = (i == 14) ? F1_MSB : '0;
    end
    vecs[15].wr_valid  = 1'b0;
    vecs[15].wr_data   = 8'h00;
    vecs[15].flush     = 1'b0;
    vecs[15].out_ready = 1'b1;
    vecs[15].exp_valid = 1'b0;
    vecs[15].exp_len   = 4'd0;
    vecs[15].exp_count = 3'd0;
    vecs[15].exp_lsb   = '0;
    vecs[15].exp_msb   = '0;

    // Reset state
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    check("rst_wr_ready", bus_lsb.wr_ready, 1'b1);
    check("rst_overflow", bus_lsb.overflow, 1'b0);
    check_empty("rst");
    rst = 1'b1;

    // Single frame and lane order
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].wr_valid, vecs[i].wr_data, vecs[i].flush, vecs[i].out_ready, 1'b0);
      tick();
      check($sformatf("vec%0d_valid", i), bus_lsb.out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_len", i), bus_lsb.out_len, vecs[i].exp_len);
      check($sformatf("vec%0d_count", i), bus_lsb.count, vecs[i].exp_count);
      check($sformatf("vec%0d_lsb", i), bus_lsb.out_data, vecs[i].exp_lsb);
      check($sformatf("vec%0d_msb", i), bus_msb.out_data, vecs[i].exp_msb);
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill to DEPTH, drop, sticky overflow, set-wins-over-clear
    write_words(8'h20, 15);
    write_words(8'h30, 15);
    write_words(8'h40, 15);
    write_words(8'h50, 15);
    check("full_count", bus_lsb.count, 4);
    check("full_wr_ready", bus_lsb.wr_ready, 1'b0);
    check("full_overflow", bus_lsb.overflow, 1'b0);
    check_head("full_head", 8'h20, 15);
    set_in(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    tick();
    check("drop_overflow", bus_lsb.overflow, 1'b1);
    check("drop_count", bus_lsb.count, 4);
    set_in(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    tick();
    check("set_wins_overflow", bus_lsb.overflow, 1'b1);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    check("ovf_clr", bus_lsb.overflow, 1'b0);

    // Pop while full with a word in the same cycle: word is still dropped
    set_in(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    tick();
    check("popfull_count", bus_lsb.count, 3);
    check("popfull_wr_ready", bus_lsb.wr_ready, 1'b1);
    check("popfull_overflow", bus_lsb.overflow, 1'b1);
    check_head("popfull_head", 8'h30, 15);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    check("ovf_clr2", bus_lsb.overflow, 1'b0);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_head("drain_head40", 8'h40, 15);
    tick();
    check_head("drain_head50", 8'h50, 15);
    tick();
    check_empty("drained");

    // Flush with nothing pending is ignored (dropped words left no partial frame)
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check_empty("flush_empty");

    // Flush after three words
    write_words(8'hAA, 1);
    write_words(8'hBB, 1);
    write_words(8'hCC, 1);
    check("preflush_count", bus_lsb.count, 0);
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check("flush_count", bus_lsb.count, 1);
    check("flush_len", bus_lsb.out_len, 3);
    check("flush_lsb", bus_lsb.out_data, ABC_LSB);
    check("flush_msb", bus_msb.out_data, ABC_MSB);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_empty("flush_pop");

    // Flush coincident with the third word
    write_words(8'hAA, 1);
    write_words(8'hBB, 1);
    set_in(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    tick();
    check("coflush_count", bus_lsb.count, 1);
    check("coflush_len", bus_lsb.out_len, 3);
    check("coflush_lsb", bus_lsb.out_data, ABC_LSB);
    check("coflush_msb", bus_msb.out_data, ABC_MSB);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_empty("coflush_pop");

    // Flush coincident with a full-frame commit yields exactly one frame
    write_words(8'h90, 14);
    set_in(1'b1, 8'h9E, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("fullflush_count", bus_lsb.count, 1);
    check_head("fullflush_head", 8'h90, 15);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_empty("fullflush_pop");

    // Commit and pop in the same cycle at count = 2
    write_words(8'h60, 15);
    write_words(8'h70, 15);
    write_words(8'h80, 14);
    check("pre_simul_count", bus_lsb.count, 2);
    set_in(1'b1, 8'h8E, 1'b0, 1'b1, 1'b0);
    tick();
    check("simul_count", bus_lsb.count, 2);
    check_head("simul_head", 8'h70, 15);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_head("simul_next", 8'h80, 15);
    tick();
    check_empty("simul_drain");

    // Stream 10 frames with random consumer backpressure across pointer wrap
    sent   = 0;
    popped = 0;
    cyc    = 0;
    while (popped < 10 && cyc < 3000) begin
      v = (sent < 150) && bus_lsb.wr_ready;
      d = 8'(16 * (sent / 15 + 1) + sent % 15);
      r = ($urandom_range(0, 2) == 0);
      set_in(v, d, 1'b0, r, 1'b0);
      if (bus_lsb.out_valid && r) begin
        check($sformatf("stream%0d_len", popped), bus_lsb.out_len, 15);
        check($sformatf("stream%0d_lsb", popped), bus_lsb.out_data,
              make_frame(8'(16 * (popped + 1)), 15, 1'b0));
        check($sformatf("stream%0d_msb", popped), bus_msb.out_data,
              make_frame(8'(16 * (popped + 1)), 15, 1'b1));
        popped++;
      end
      if (v) sent++;
      tick();
      cyc++;
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("stream_frames", popped, 10);
    check("stream_overflow", bus_lsb.overflow, 1'b0);
    check_empty("stream_end");

    // Reset mid-frame with one frame queued
    write_words(8'hB0, 15);
    write_words(8'hD0, 7);
    check("prerst_count", bus_lsb.count, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_wr_ready", bus_lsb.wr_ready, 1'b1);
    check_empty("midrst");
    write_words(8'hC0, 15);
    check("postrst_count", bus_lsb.count, 1);
    check_head("postrst_head", 8'hC0, 15);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    check_empty("postrst_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_rx_frame_fifo.md
# spi_rx_frame_fifo

Parametrised receive-side frame buffer for the SPI MISO path, operating in a single clock domain. It packs a stream of DSIZE-bit received words into frames of FRAME_BYTES words and queues up to DEPTH complete frames. Frames are presented as a wide word with a valid/ready handshake. It supports partial-frame flush, configurable lane order, and a sticky overflow flag, so a non-backpressurable SPI link never silently corrupts a frame.

## Interface
- DSIZE, 8: width of one received word.
- FRAME_BYTES, 15: words per frame; frame width FW = FRAME_BYTES*DSIZE (120 by default).
- DEPTH, 4: frames stored; power of 2, ≥2.
- MSB_FIRST, 0: 0 = word i of a frame lands at bits [i*DSIZE +: DSIZE]; 1 = word i lands at lane FRAME_BYTES-1-i.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_valid  in  1  received word present this cycle.
- wr_data  in  DSIZE  received word.
- wr_ready  out  1  registered; 1 when count < DEPTH.
- frame_flush  in  1  pulse; closes the current partial frame.
- out_valid  out  1  at least one frame is queued (count != 0).
- out_ready  in  1  consumer accepts the head frame.
- out_data  out  FW  head frame; forced to 0 when out_valid = 0.
- out_len  out  $clog2(FRAME_BYTES+1)  valid words in the head frame; 0 when out_valid = 0.
- count  out  $clog2(DEPTH+1)  frames queued.
- overflow  out  1  sticky drop indicator.
- ovf_clr  in  1  clears overflow.

## Operation
- **Reset (rst = 0 at edge):**
  - byte_cnt, wr_ptr, rd_ptr and count go to 0; the packing shadow register is zeroed; overflow goes to 0.
  - Outputs after reset: wr_ready = 1, out_valid = 0, out_data = 0, out_len = 0, count = 0.
  - Frame memory is not reset.
- **Word accept:** a word is accepted when wr_valid && wr_ready. It is written into the shadow at the lane selected by byte_cnt and MSB_FIRST, and byte_cnt increments.
- **Drop:** wr_valid && !wr_ready discards the word, sets overflow, and leaves byte_cnt unchanged.
- **Commit:** occurs when an accepted word brings byte_cnt to FRAME_BYTES.
  - The shadow, including the current word, is written to mem[wr_ptr] with len = FRAME_BYTES.
  - wr_ptr increments modulo DEPTH; byte_cnt and the shadow clear.
- **Flush:** frame_flush with an effective length > 0 commits the shadow with len = effective length. Unfilled lanes are 0.
  - Effective length = byte_cnt, plus 1 if a word is accepted in the same cycle; that word is included.
  - Flush with effective length 0 is ignored.
  - Flush coincident with a full-frame commit is absorbed by that commit; no empty frame is produced.
- **Flush while full:** flush with wr_ready = 0 drops the partial frame, sets overflow, and clears byte_cnt and the shadow.
- **Pop:** occurs on out_valid && out_ready. rd_ptr increments modulo DEPTH.
- **Count update:**
  - count +1 on commit only.
  - count −1 on pop only.
  - Unchanged when a commit and a pop occur in the same cycle.
- **Head frame:** out_data and out_len are read combinationally from mem[rd_ptr] (first-word fall-through).
- **Overflow register:** overflow is set by any drop and cleared by ovf_clr. If a set and ovf_clr occur in the same cycle, set wins.

## Timing
- **Commit to output:** a frame committed at edge t is visible as out_valid = 1, with data, from after edge t (count updates at t). There is no extra latency when the FIFO was empty.
- **wr_ready:** derived from the registered count. A pop at edge t re-enables writes from after t; a word presented in the same cycle as that pop, while full, is dropped.
- **Output stability:** out_data and out_len hold stable while out_valid && !out_ready.
- **Pointer wrap:** wr_ptr and rd_ptr wrap DEPTH-1 → 0 with no bubble.
- **Reset mid-frame:** the partial frame and all queued frames are discarded; there is no output glitch beyond out_valid falling after the reset edge.

## Test plan
1. **Single frame:** MSB_FIRST = 0; write 0x01..0x0F on consecutive cycles.
   - After the 15th edge: out_valid = 1, out_data[7:0] = 0x01, out_data[119:112] = 0x0F, out_len = 15, count = 1.
   - Pop → out_valid = 0, out_data = 0.
2. **Lane order:** MSB_FIRST = 1, same stimulus → out_data[119:112] = 0x01, out_data[7:0] = 0x0F.
3. **Fill and overflow:** write 4 full frames with out_ready = 0.
   - Expect count = 4, wr_ready = 0.
   - Write 0xEE → dropped, overflow = 1, byte_cnt = 0.
   - ovf_clr → overflow = 0.
4. **Flush:**
   - Write 0xAA, 0xBB, 0xCC, then flush → out_len = 3, lanes 0..2 = AA/BB/CC, lanes 3..14 = 0.
   - Repeat with flush coincident with 0xCC → identical frame.
   - Flush with no words pending → count unchanged.
5. **Simultaneous events and wrap:**
   - At count = 2, commit and pop in the same cycle → count stays 2.
   - Stream 10 frames (first word 0x10*k) with random out_ready → frames emerge in order across pointer wrap; no overflow.
6. **Reset mid-frame:** after 7 words and 1 queued frame, rst = 0 for one cycle.
   - Expect count = 0, out_valid = 0.
   - The next 15 words form one clean frame with out_len = 15.
